bin_to_bcd_seq: RTL and testbench



---
 rtl/bin_to_bcd_seq.sv | 136 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clk_in cycle.
// Optional macro SIGNED_INPUT_EN: two's-complement input, magnitude converted, sign on neg.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic                  state_dbg,
  output logic [4*DIGITS-1:0]   bcd
`ifdef SIGNED_INPUT_EN
  ,
  output logic                  neg
`endif
);

  // Handshake: start is sampled only while IDLE (busy=0); busy stays high for
  // WIDTH cycles; done pulses for one cycle exactly when bcd takes its new value.

  localparam int BW         = 4 * DIGITS;
  localparam int CW         = $clog2(WIDTH + 1);
  localparam int MIN_DIGITS = (WIDTH * 30103 + 99999) / 100000;

  if (DIGITS < MIN_DIGITS) begin : g_digits_check
    $error("bin_to_bcd_seq: DIGITS too small to hold a WIDTH-bit value");
  end

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [BW-1:0]     scratch_q, scratch_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bcd_d;
  logic              done_d;
  logic [BW-1:0]     adj;
  logic [BW+WIDTH-1:0] shifted;
  logic [WIDTH-1:0]  load_val;
  logic              load_neg;
  logic [3:0]        nib;

`ifdef SIGNED_INPUT_EN
  logic sign_q, sign_d, neg_d;
  // Unsigned negation, so the most negative input yields 2^(WIDTH-1).
  assign load_neg = binary[WIDTH-1];
  assign load_val = load_neg ? (~binary + WIDTH'(1)) : binary;
`else
  assign load_neg = 1'b0;
  assign load_val = binary;
`endif

  assign busy      = (state_q == SHIFT);
  assign state_dbg = state_q;

  // Per-digit +3 correction; nibbles never carry into each other.
  always_comb begin
    adj = scratch_q;
    nib = 4'd0;
    for (int d = 0; d < DIGITS; d++) begin
      nib = scratch_q[4*d +: 4];
      adj[4*d +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
    shifted = {adj, shift_q} << 1;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd;
    done_d    = 1'b0;
`ifdef SIGNED_INPUT_EN
    sign_d    = sign_q;
    neg_d     = neg;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = load_val;
          scratch_d = '0;
          cnt_d     = CW'(WIDTH);
          state_d   = SHIFT;
`ifdef SIGNED_INPUT_EN
          sign_d    = load_neg;
`endif
        end
      end
      SHIFT: begin
        scratch_d = shifted[BW+WIDTH-1:WIDTH];
        shift_d   = shifted[WIDTH-1:0];
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = shifted[BW+WIDTH-1:WIDTH];
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef SIGNED_INPUT_EN
          neg_d   = sign_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd       <= '0;
      done      <= 1'b0;
`ifdef SIGNED_INPUT_EN
      sign_q    <= 1'b0;
      neg       <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd       <= bcd_d;
      done      <= done_d;
`ifdef SIGNED_INPUT_EN
      sign_q    <= sign_d;
      neg       <= neg_d;
`endif
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed-vector bench for bin_to_bcd_seq (define SIGNED_INPUT_EN for the signed checks).
module tb_bin_to_bcd_seq;

  localparam int W  = 32;
  localparam int D  = 10;
  localparam int BW = 4 * D;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start;
  logic [W-1:0]  binary;
  logic          busy;
  logic          done;
  logic          state_dbg;
  logic [BW-1:0] bcd;
`ifdef SIGNED_INPUT_EN
  logic          neg;
`endif

  int checks = 0;
  int errors = 0;

  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start(start), .binary(binary),
    .busy(busy), .done(done), .state_dbg(state_dbg), .bcd(bcd)
`ifdef SIGNED_INPUT_EN
    , .neg(neg)
`endif
  );

  always #100 clk_in = ~clk_in;

  task automatic begin_conv(input logic [W-1:0] v);
    @(negedge clk_in);
    start  = 1'b1;
    binary = v;
  endtask

  // Follows one conversion from its accepting edge; optional second start pulse at inject_at.
  task automatic run_to_done(input logic [BW-1:0] prev, input int inject_at,
                             input logic [W-1:0] inject_val, output int lat,
                             output int done_cnt, output int busy_cnt, output bit held);
    lat = -1; done_cnt = 0; busy_cnt = 0; held = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    start = 1'b0;
    for (int i = 0; i < W + 16; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat < 0) lat = i;
      end else if (done_cnt == 0 && bcd !== prev) begin
        held = 1'b0;
      end
      if (i == inject_at) begin
        start = 1'b1; binary = inject_val;
      end else begin
        start = 1'b0; binary = $urandom;
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1; start = 1'b0; binary = '0;
    repeat (2) @(negedge clk_in);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (bcd !== '0) begin errors++; $display("FAIL reset_bcd: got %h expected 0", bcd); end
    checks++; if (state_dbg !== 1'b0) begin errors++; $display("FAIL reset_state: got %b expected 0", state_dbg); end
`ifdef SIGNED_INPUT_EN
    checks++; if (neg !== 1'b0) begin errors++; $display("FAIL reset_neg: got %b expected 0", neg); end
`endif
    rst_in = 1'b0;
    @(negedge clk_in);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_convert(input logic [W-1:0] v, input logic [BW-1:0] prev,
                              input logic [BW-1:0] exp_bcd);
    int lat, dc, bc;
    bit held;
    begin_conv(v);
    run_to_done(prev, -1, '0, lat, dc, bc, held);
    checks++; if (lat != W) begin errors++; $display("FAIL latency(%0d): got %0d expected %0d", v, lat, W); end
    checks++; if (dc != 1) begin errors++; $display("FAIL done_pulses(%0d): got %0d expected 1", v, dc); end
    checks++; if (bc != W) begin errors++; $display("FAIL busy_cycles(%0d): got %0d expected %0d", v, bc, W); end
    checks++; if (!held) begin errors++; $display("FAIL bcd_hold(%0d): got changed expected held %h", v, prev); end
    checks++; if (bcd !== exp_bcd) begin errors++; $display("FAIL bcd(%0d): got %h expected %h", v, bcd, exp_bcd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after(%0d): got %b expected 0", v, busy); end
  endtask

  task automatic test_ignore_busy(input logic [BW-1:0] prev);
    int lat, dc, bc;
    bit held;
    begin_conv(32'd9);
    run_to_done(prev, 10, 32'd5, lat, dc, bc, held);
    checks++; if (lat != W) begin errors++; $display("FAIL ign_latency: got %0d expected %0d", lat, W); end
    checks++; if (dc != 1) begin errors++; $display("FAIL ign_done_pulses: got %0d expected 1", dc); end
    checks++; if (bc != W) begin errors++; $display("FAIL ign_busy_cycles: got %0d expected %0d", bc, W); end
    checks++; if (!held) begin errors++; $display("FAIL ign_bcd_hold: got changed expected held %h", prev); end
    checks++; if (bcd !== 40'h9) begin errors++; $display("FAIL ign_bcd: got %h expected %h", bcd, 40'h9); end
  endtask

  task automatic test_reset_abort();
    int dc;
    begin_conv(32'd777);
    @(posedge clk_in);
    @(negedge clk_in);
    start = 1'b0;
    repeat (14) @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (bcd !== '0) begin errors++; $display("FAIL abort_bcd: got %h expected 0", bcd); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", done); end
    @(negedge clk_in);
    rst_in = 1'b0;
    dc = 0;
    repeat (W + 4) begin
      @(negedge clk_in);
      if (done) dc++;
    end
    checks++; if (dc != 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", dc); end
    test_convert(32'd100, '0, 40'h100);
  endtask

  task automatic test_back_to_back(input logic [BW-1:0] prev);
    int lat, dc, bc, cnt;
    bit held;
    begin_conv(32'd12);
    run_to_done(prev, W, 32'd34, lat, dc, bc, held);
    checks++; if (lat != W) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, W); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_busy: got %b expected 1", busy); end
    checks++; if (bcd !== 40'h12) begin errors++; $display("FAIL b2b_first_bcd: got %h expected %h", bcd, 40'h12); end
    cnt = 0;
    while (!done && cnt < 100) begin
      @(negedge clk_in);
      cnt++;
    end
    checks++; if (cnt != W - 15) begin errors++; $display("FAIL b2b_second_wait: got %0d expected %0d", cnt, W - 15); end
    checks++; if (bcd !== 40'h34) begin errors++; $display("FAIL b2b_second_bcd: got %h expected %h", bcd, 40'h34); end
    @(negedge clk_in);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_width: got %b expected 0", done); end
  endtask

`ifdef SIGNED_INPUT_EN
  task automatic test_signed();
    logic [W-1:0]  vin [3];
    logic [BW-1:0] vexp [3];
    logic          vneg [3];
    logic [BW-1:0] prev;
    int lat, dc, bc;
    bit held;
    vin[0] = 32'hFFFFFFF6; vexp[0] = 40'h10;         vneg[0] = 1'b1;
    vin[1] = 32'h80000000; vexp[1] = 40'h2147483648; vneg[1] = 1'b1;
    vin[2] = 32'd42;       vexp[2] = 40'h42;         vneg[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      prev = bcd;
      begin_conv(vin[k]);
      run_to_done(prev, -1, '0, lat, dc, bc, held);
      checks++; if (dc != 1) begin errors++; $display("FAIL signed_done(%h): got %0d expected 1", vin[k], dc); end
      checks++; if (bcd !== vexp[k]) begin errors++; $display("FAIL signed_bcd(%h): got %h expected %h", vin[k], bcd, vexp[k]); end
      checks++; if (neg !== vneg[k]) begin errors++; $display("FAIL signed_neg(%h): got %b expected %b", vin[k], neg, vneg[k]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_convert(32'd0, '0, 40'h0);
    test_convert(32'd12345678, 40'h0, 40'h0012345678);
`ifdef SIGNED_INPUT_EN
    test_convert(32'hFFFFFFFF, 40'h0012345678, 40'h1);
    test_ignore_busy(40'h1);
`else
    test_convert(32'hFFFFFFFF, 40'h0012345678, 40'h4294967295);
    test_ignore_busy(40'h4294967295);
`endif
    test_reset_abort();
    test_back_to_back(40'h100);
`ifdef SIGNED_INPUT_EN
    test_signed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
